// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply/divide unit for the EX stage. One operation takes
//   WIDTH iterations plus a sign-fix cycle; busy stalls the upstream
//   pipeline registers while it runs, and done pulses for one cycle with
//   the registered result and destination.
//
//   Configuration macro: EX_MULDIV_DIV_EN
//     defined   : MUL, MULH, DIV and REM are all supported.
//     undefined : the divider is compiled out. DIV/REM complete one edge
//                 after start with result 0 and div_zero 0.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   flush           abort the current operation (wins over start)
//   start           request, sampled only while idle
//   op[1:0]         00 MUL, 01 MULH, 10 DIV, 11 REM
//   a, b            operands (dividend / divisor for DIV and REM)
//   dst_in          destination register index
//   busy            stall request to upstream stages
//   done            one-cycle result-valid pulse
//   result          registered result, valid while done
//   dst_out         registered destination, valid while done
//   div_zero        divisor was zero, valid while done
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int DST_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [DST_W-1:0] dst_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [DST_W-1:0] dst_out,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [DST_W-1:0]   dst_lat_q, dst_lat_d;
  logic               neg_q, neg_d;
  // acc holds {high, low} of the product, or {remainder, quotient} when dividing
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // multiplicand, or divisor magnitude
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [DST_W-1:0]   dst_out_q, dst_out_d;
  logic               div_zero_q, div_zero_d;
`ifdef EX_MULDIV_DIV_EN
  logic               sa_q, sa_d;
  logic               dz_q, dz_d;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo, rem;
`endif

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;

  // Datapath step values and the FSM next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dst_lat_d  = dst_lat_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    result_d   = result_q;
    dst_out_d  = dst_out_q;
    div_zero_d = div_zero_q;

    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;

    // shift-add: add multiplicand to the high half when the current LSB is set
    add      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {add, acc_q[WIDTH-1:1]};
    prod_fix = neg_q ? -acc_q : acc_q;

`ifdef EX_MULDIV_DIV_EN
    sa_d = sa_q;
    dz_d = dz_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    // restoring step: shifted partial remainder minus divisor; MSB is the borrow
    diff = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, opb_q};
    if (diff[WIDTH+1])
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    else
      div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d      = op;
          dst_lat_d = dst_in;
          cnt_d     = '0;
          state_d   = S_CALC;
          if (op[1]) begin
`ifdef EX_MULDIV_DIV_EN
            neg_d = a[WIDTH-1] ^ b[WIDTH-1];
            sa_d  = a[WIDTH-1];
            dz_d  = (b == '0);
            acc_d = {{WIDTH{1'b0}}, abs_a};
            opb_d = abs_b;
`else
            result_d   = '0;
            dst_out_d  = dst_in;
            div_zero_d = 1'b0;
            state_d    = S_DONE;
`endif
          end else if (op == OP_MULH) begin
            neg_d = a[WIDTH-1] ^ b[WIDTH-1];
            acc_d = {{WIDTH{1'b0}}, abs_a};
            opb_d = abs_b;
`ifdef EX_MULDIV_DIV_EN
            dz_d  = 1'b0;
`endif
          end else begin
            // low half of the product is the same for signed and unsigned
            neg_d = 1'b0;
            acc_d = {{WIDTH{1'b0}}, a};
            opb_d = b;
`ifdef EX_MULDIV_DIV_EN
            dz_d  = 1'b0;
`endif
          end
        end
      end
      S_CALC: begin
`ifdef EX_MULDIV_DIV_EN
        acc_d = op_q[1] ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (!flush) begin
          dst_out_d  = dst_lat_q;
          div_zero_d = 1'b0;
          case (op_q)
            OP_MULH: result_d = prod_fix[2*WIDTH-1:WIDTH];
`ifdef EX_MULDIV_DIV_EN
            // a zero divisor leaves the remainder equal to |a|, so REM needs no override
            OP_DIV: begin
              result_d   = dz_q ? '1 : (neg_q ? -quo : quo);
              div_zero_d = dz_q;
            end
            OP_REM: begin
              result_d   = sa_q ? -rem : rem;
              div_zero_d = dz_q;
            end
`endif
            default: result_d = acc_q[WIDTH-1:0];
          endcase
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush)
      state_d = S_IDLE;
  end

  // All state, reset asynchronously to an idle unit with cleared outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      dst_lat_q  <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      dst_out_q  <= '0;
      div_zero_q <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
      sa_q       <= 1'b0;
      dz_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dst_lat_q  <= dst_lat_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      dst_out_q  <= dst_out_d;
      div_zero_q <= div_zero_d;
`ifdef EX_MULDIV_DIV_EN
      sa_q       <= sa_d;
      dz_q       <= dz_d;
`endif
    end
  end

  // busy covers the start cycle, every CALC cycle and the FIX cycle
  assign busy = !rst && ((state_q == S_IDLE && start && !flush) ||
                         state_q == S_CALC || state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign dst_out  = dst_out_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
//   Self-checking bench for ex_muldiv_unit (WIDTH=32, DST_W=4). Expected
//   results come from a plain-arithmetic reference function; the build
//   option EX_MULDIV_DIV_EN selects which DIV/REM behaviour is expected.
module tb_ex_muldiv_unit;

  localparam int WIDTH = 32;
  localparam int DST_W = 4;
`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [DST_W-1:0] dstIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [DST_W-1:0] dstOut;
  logic             divZero;

  int vecCount  = 0;
  int missCount = 0;

  logic [WIDTH-1:0] lastRes = '0;
  logic [DST_W-1:0] lastDst = '0;
  logic             lastDz  = 1'b0;

  ex_muldiv_unit #(.WIDTH(WIDTH), .DST_W(DST_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .dst_in   (dstIn),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .dst_out  (dstOut),
    .div_zero (divZero)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {div_zero, result} from plain signed arithmetic
  function automatic logic [WIDTH:0] refModel(input logic [1:0] o, input logic [WIDTH-1:0] av,
                                              input logic [WIDTH-1:0] bv);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    p  = 64'(sa * sb);
    case (o)
      2'b00: return {1'b0, p[31:0]};
      2'b01: return {1'b0, p[63:32]};
      default: begin
        if (!DIV_EN) return '0;
        if (bv == 0) return (o == 2'b10) ? {1'b1, 32'hFFFF_FFFF} : {1'b1, av};
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF)
          return (o == 2'b10) ? {1'b0, av} : '0;
        if (o == 2'b10) p = 64'(sa / sb);
        else            p = 64'(sa % sb);
        return {1'b0, p[31:0]};
      end
    endcase
  endfunction

  // Issue one operation (called at a negedge with the unit idle), wait for
  // done and check latency, busy span and outputs. Returns at the done cycle.
  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic [DST_W-1:0] d,
                               input logic [WIDTH-1:0] expRes, input logic expDz,
                               input bit noise);
    int edges;
    int expLat;
    bit busyOk;
    start = 1'b1; op = o; a = av; b = bv; dstIn = d;
    #1;
    busyOk = (busy === 1'b1);
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    edges  = 0;
    expLat = (o[1] && !DIV_EN) ? 0 : WIDTH + 1;
    while (done !== 1'b1 && edges <= WIDTH + 8) begin
      if (busy !== 1'b1) busyOk = 0;
      if (noise && edges < 4) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
        dstIn = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    if (busy !== 1'b0) busyOk = 0;
    checkOutput("done_seen", 64'(done), 64'd1);
    checkOutput("latency", 64'(edges), 64'(expLat));
    checkOutput("busy_span", 64'(busyOk), 64'd1);
    checkOutput("result", 64'(result), 64'(expRes));
    checkOutput("dst_out", 64'(dstOut), 64'(d));
    checkOutput("div_zero", 64'(divZero), 64'(expDz));
    lastRes = expRes;
    lastDst = d;
    lastDz  = expDz;
  endtask

  // Step past the done cycle and confirm done was a single-cycle pulse
  task automatic afterDone();
    @(negedge clk);
    checkOutput("done_pulse", 64'(done), 64'd0);
  endtask

  typedef struct {
    logic [1:0]       o;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic [DST_W-1:0] d;
    logic [WIDTH-1:0] expRes;
    logic             expDz;
  } vec_t;

  vec_t dirVecs[$];

  initial begin
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] ra, rb;
    logic [1:0]       ro;
    bit sawDone, sawBusy;

    rst = 1'b1; flush = 1'b0; start = 1'b1; op = 2'b00; a = '0; b = '0; dstIn = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_dst", 64'(dstOut), 64'd0);
    checkOutput("rst_dz", 64'(divZero), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    dirVecs.push_back('{2'b00, 32'd7, 32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB, 1'b0});
    dirVecs.push_back('{2'b01, 32'h8000_0000, 32'd2, 4'd6, 32'hFFFF_FFFF, 1'b0});
    dirVecs.push_back('{2'b01, 32'h4000_0000, 32'd4, 4'd7, 32'h0000_0001, 1'b0});
    dirVecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 4'd1, DIV_EN ? 32'hFFFF_FFFD : 32'h0, 1'b0});
    dirVecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2, 4'd2, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1'b0});
    dirVecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd3, DIV_EN ? 32'h8000_0000 : 32'h0, 1'b0});
    dirVecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 32'h0, 1'b0});
    dirVecs.push_back('{2'b10, 32'h0000_1234, 32'd0, 4'd8, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN});
    dirVecs.push_back('{2'b11, 32'h0000_1234, 32'd0, 4'd9, DIV_EN ? 32'h0000_1234 : 32'h0, DIV_EN});
    dirVecs.push_back('{2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 4'd10, 32'h0111_1111 - 32'h1234_5678 + 32'h0, 1'b0});
    // last entry recomputed: MULH of a positive by a negative operand
    dirVecs[9].expRes = refModel(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);

    foreach (dirVecs[i]) begin
      applyStimulus(dirVecs[i].o, dirVecs[i].av, dirVecs[i].bv, dirVecs[i].d,
                    dirVecs[i].expRes, dirVecs[i].expDz, i[0]);
      afterDone();
    end

    // Flush partway through a long operation
    start = 1'b1; op = DIV_EN ? 2'b10 : 2'b00; a = 32'd100; b = 32'd7; dstIn = 4'd12;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_done", 64'(done), 64'd0);
    checkOutput("flush_result", 64'(result), 64'(lastRes));
    checkOutput("flush_dst", 64'(dstOut), 64'(lastDst));
    sawDone = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("flush_no_done", 64'(sawDone), 64'd0);
    applyStimulus(2'b00, 32'd1000, 32'd3000, 4'd11, 32'd3000000, 1'b0, 0);
    afterDone();

    // start together with flush in idle starts nothing
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; dstIn = 4'd13;
    #1;
    checkOutput("startflush_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    sawBusy = 0; sawDone = 0;
    repeat (WIDTH + 4) begin
      if (busy) sawBusy = 1;
      if (done) sawDone = 1;
      @(negedge clk);
    end
    checkOutput("startflush_idle", 64'({sawBusy, sawDone}), 64'd0);
    checkOutput("startflush_result", 64'(result), 64'(lastRes));

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = '0; end
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($signed(8'($urandom))); rb = 32'($signed(8'($urandom))); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      m = refModel(ro, ra, rb);
      applyStimulus(ro, ra, rb, 4'($urandom_range(0, 15)), m[WIDTH-1:0], m[WIDTH], ($urandom_range(0, 3) == 0));
      afterDone();
    end

    // Reset in the middle of a calculation
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3; dstIn = 4'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_result", 64'(result), 64'd0);
    checkOutput("midrst_dst", 64'(dstOut), 64'd0);
    checkOutput("midrst_dz", 64'(divZero), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m = refModel(2'b11, 32'hFFFF_FF9C, 32'd7);
    applyStimulus(2'b11, 32'hFFFF_FF9C, 32'd7, 4'd14, m[WIDTH-1:0], m[WIDTH], 0);
    afterDone();
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'd1, 1'b0, 0);
    afterDone();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
